mem_manager_rw: RTL
===================

Name: mem_manager_rw

Overview:
Parametrised successor to the single-word write memory manager for the AXI slave.
- Owns the slave's word-addressed storage array.
- Serves incrementing write bursts with byte strobes and incrementing read bursts over separate request/data handshakes.
- Arbitrates round-robin between write and read requesters and exposes one busy flag.
- Sits between the slave's AW/W/B and AR/R channel logic and the storage.

Parameters:
ADDR_W, 10, word address width; array holds 2**ADDR_W words
DATA_W, 32, data width in bits; must be a multiple of 8
LEN_W, 4, burst length field width; beats = LEN+1 (1..16 at default)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  reset, synchronous, active-low
WR_REQ  in  1  write burst request; held until WR_GNT
WR_ADDR  in  ADDR_W  write burst start word address
WR_LEN  in  LEN_W  write beats minus one
WR_GNT  out  1  one-cycle pulse: write burst accepted
WR_DATA  in  DATA_W  write beat data
WR_STRB  in  DATA_W/8  byte enables, bit i -> byte i
WR_VALID  in  1  write beat valid
WR_READY  out  1  write beat accepted when VALID&READY
WR_DONE  out  1  one-cycle pulse after last write beat committed
RD_REQ  in  1  read burst request; held until RD_GNT
RD_ADDR  in  ADDR_W  read burst start word address
RD_LEN  in  LEN_W  read beats minus one
RD_GNT  out  1  one-cycle pulse: read burst accepted
RD_DATA  out  DATA_W  read beat data, registered
RD_VALID  out  1  read beat valid
RD_READY  in  1  read beat consumed when VALID&READY
RD_LAST  out  1  qualifies final read beat
MEM_BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset (ARESETn=0 at an edge):
  - State goes to IDLE and the round-robin pointer is set to prefer write.
  - All outputs go to 0.
  - Array contents are not cleared.
  - A beat presented in the reset cycle is not written.
  - Reset mid-burst abandons the burst with no DONE or LAST.
- State machine: IDLE, WRITE, READ.
  - IDLE: if exactly one REQ is high, that request wins. If both are high, the side not granted last wins. On that edge, the start address and LEN are captured into the address register and the beat counter, and the state moves to WRITE or READ. The matching GNT is high for exactly the first cycle in the new state.
  - Requests are not sampled while not in IDLE. At least one IDLE cycle separates consecutive bursts.
- WRITE:
  - WR_READY = 1 combinationally in WRITE only.
  - On each VALID&READY, byte i of mem[addr] is updated only where WR_STRB[i]=1. The address then increments and the counter decrements.
  - When the beat with counter==0 is accepted, the state returns to IDLE and WR_DONE is high for that following cycle.
  - WR_VALID low inserts wait cycles with no side effects.
- READ:
  - RD_DATA and RD_VALID are registered; the first beat is valid in the cycle after GNT.
  - When VALID&READY and beats remain, the next word loads with zero bubble.
  - When VALID&READY on the LAST beat, RD_VALID drops the next cycle and the state returns to IDLE.
  - With RD_READY low, RD_DATA, RD_VALID and RD_LAST hold stable.
- Address arithmetic: increments modulo 2**ADDR_W, so bursts wrap from 2**ADDR_W-1 to 0 with no error.
- Ordering: a read granted after a write's DONE returns the written data; there is no write/read overlap.
- Latency: a one-beat write takes REQ→GNT 1 cycle, beat 1 cycle, DONE 1 cycle.

Decomposition:
- Package mem_mgr_pkg holds:
  - typedef enum logic [1:0] {IDLE, WRITE, READ} mgr_state_t
  - default ADDR_W, DATA_W and LEN_W localparams
  - a function strb_merge(old, new, strb) for the byte-merge.
- One sub-module, mem_bank_strb: single-port array with byte-enable write and a registered read with a load-enable. mem_manager_rw keeps the FSM, arbiter, counters and handshakes.

Test Plan:
- Reset, then 3 idle cycles → all outputs 0, MEM_BUSY=0.
- Write addr 0x005, LEN 0, data 0xDEADBEEF, strb 4'hF → WR_GNT, WR_DONE pulses. Then read 0x005 → RD_DATA=0xDEADBEEF with RD_LAST=1.
- Write 0x005 with 0x11223344, strb 4'b0101 → a subsequent read returns 0xDE22BE44.
- Write burst at 0x3FE, LEN 2, data 1,2,3 with WR_VALID gapped → words 0x3FE=1, 0x3FF=2, 0x000=3. Read back gives the same values with RD_LAST on the 3rd beat.
- WR_REQ and RD_REQ both high from reset → write granted first. After it completes and both are held again, read is granted.
- 4-beat read with RD_READY low on beat 2 for 3 cycles → RD_DATA held stable and the order is preserved. Assert ARESETn=0 during beat 3 → next cycle RD_VALID=0, MEM_BUSY=0, no RD_LAST.

Source files
------------

// File: rtl/mem_manager_rw_pkg.sv
// Shared types, default widths and the byte-merge helper for the memory manager.
package mem_mgr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } mgr_state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Replace byte i of old_word with byte i of new_word wherever strb[i] is set.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_bank_strb.sv
// Single-port word array: byte-enabled write, registered read with load enable.
module mem_bank_strb
    import mem_mgr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                re,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem_array [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_reg;

    // Storage is never cleared; only enabled byte lanes of the addressed word change.
    always_ff @(posedge ACLK) begin
        if (we) begin
            mem_array[addr] <= DATA_W'(strb_merge(MAX_DATA_W'(mem_array[addr]),
                                                  MAX_DATA_W'(wdata),
                                                  MAX_STRB_W'(wstrb)));
        end
    end

    // Output register loads only on request, so it holds while the consumer stalls.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_array[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_manager_rw.sv
// Burst write/read memory manager with round-robin arbitration between the two requesters.
module mem_manager_rw
    import mem_mgr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                WR_REQ,
    input  logic [ADDR_W-1:0]   WR_ADDR,
    input  logic [LEN_W-1:0]    WR_LEN,
    output logic                WR_GNT,
    input  logic [DATA_W-1:0]   WR_DATA,
    input  logic [DATA_W/8-1:0] WR_STRB,
    input  logic                WR_VALID,
    output logic                WR_READY,
    output logic                WR_DONE,
    input  logic                RD_REQ,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    input  logic [LEN_W-1:0]    RD_LEN,
    output logic                RD_GNT,
    output logic [DATA_W-1:0]   RD_DATA,
    output logic                RD_VALID,
    input  logic                RD_READY,
    output logic                RD_LAST,
    output logic                MEM_BUSY
);

    mgr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic              last_wr_reg, last_wr_next;   // 1: previous grant went to the writer
    logic              wr_gnt_reg, wr_gnt_next;
    logic              rd_gnt_reg, rd_gnt_next;
    logic              wr_done_reg, wr_done_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              rd_last_reg, rd_last_next;
    logic              mem_we;
    logic              rd_load;

    // State and handshake registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            cnt_reg      <= '0;
            last_wr_reg  <= 1'b0;
            wr_gnt_reg   <= 1'b0;
            rd_gnt_reg   <= 1'b0;
            wr_done_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
            last_wr_reg  <= last_wr_next;
            wr_gnt_reg   <= wr_gnt_next;
            rd_gnt_reg   <= rd_gnt_next;
            wr_done_reg  <= wr_done_next;
            rd_valid_reg <= rd_valid_next;
            rd_last_reg  <= rd_last_next;
        end
    end

    // Arbitration, beat sequencing and array enables.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        last_wr_next  = last_wr_reg;
        wr_gnt_next   = 1'b0;
        rd_gnt_next   = 1'b0;
        wr_done_next  = 1'b0;
        rd_valid_next = rd_valid_reg;
        rd_last_next  = rd_last_reg;
        mem_we        = 1'b0;
        rd_load       = 1'b0;
        WR_READY      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (WR_REQ && (!RD_REQ || !last_wr_reg)) begin
                    state_next   = WRITE;
                    addr_next    = WR_ADDR;
                    cnt_next     = WR_LEN;
                    wr_gnt_next  = 1'b1;
                    last_wr_next = 1'b1;
                end else if (RD_REQ) begin
                    state_next   = READ;
                    addr_next    = RD_ADDR;
                    cnt_next     = RD_LEN;
                    rd_gnt_next  = 1'b1;
                    last_wr_next = 1'b0;
                end
            end
            WRITE: begin
                WR_READY = 1'b1;
                if (WR_VALID) begin
                    mem_we    = ARESETn;
                    addr_next = addr_reg + ADDR_W'(1);
                    cnt_next  = cnt_reg - LEN_W'(1);
                    if (cnt_reg == '0) begin
                        state_next   = IDLE;
                        wr_done_next = 1'b1;
                    end
                end
            end
            READ: begin
                // First beat loads in the grant cycle; later beats load on acceptance.
                if (rd_gnt_reg || (rd_valid_reg && RD_READY && !rd_last_reg)) begin
                    rd_load       = 1'b1;
                    rd_valid_next = 1'b1;
                    rd_last_next  = (cnt_reg == '0);
                    addr_next     = addr_reg + ADDR_W'(1);
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - LEN_W'(1);
                    end
                end else if (rd_valid_reg && RD_READY && rd_last_reg) begin
                    rd_valid_next = 1'b0;
                    rd_last_next  = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    mem_bank_strb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .addr    (addr_reg),
        .we      (mem_we),
        .wdata   (WR_DATA),
        .wstrb   (WR_STRB),
        .re      (rd_load),
        .rdata   (RD_DATA)
    );

    assign WR_GNT   = wr_gnt_reg;
    assign RD_GNT   = rd_gnt_reg;
    assign WR_DONE  = wr_done_reg;
    assign RD_VALID = rd_valid_reg;
    assign RD_LAST  = rd_last_reg;
    assign MEM_BUSY = (state_reg != IDLE);

endmodule
